bcd_ascii_sched: RTL
====================

Name: bcd_ascii_sched

Overview:
- Round-robin scheduler that shares one bin2bcd8 converter among NREQ byte requesters.
- Each granted byte is emitted as a decimal ASCII string on a single valid/ready byte stream: optional leading-zero suppression, then a separator byte.
- Sits between multiple status or counter sources and a serial/text sink, e.g. a UART TX or log FIFO.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SEP, 8'h2C, separator byte appended after each number (ASCII ',').
- SUPPRESS, 1, 1 = drop leading zero digits; 0 = always emit 3 digits.

Ports:
- CLOCK  in  1  single clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  NREQ  per-requester value-present flag.
- REQ_DATA  in  8*NREQ  packed values; requester k uses bits [8k+7:8k].
- REQ_READY  out  NREQ  one-hot grant; value k is accepted in the cycle REQ_VALID[k] & REQ_READY[k].
- OUT_VALID  out  1  OUT_DATA holds a byte.
- OUT_DATA  out  8  ASCII digit or SEP.
- OUT_LAST  out  1  high on the SEP byte only.
- OUT_SRC  out  3  index of the requester whose number is being emitted.
- OUT_READY  in  1  sink accepts the byte when OUT_VALID & OUT_READY.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr pointer=0, value/digit/src registers=0.
  - Outputs: OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, OUT_SRC=0, BUSY=0, REQ_READY=0.
- States: IDLE, CONV, HUN, TEN, ONE, SEPB.
- IDLE:
  - REQ_READY = one-hot of the first k with REQ_VALID[k]=1, searching from the pointer upward with wrap; 0 if none valid.
  - On accept: latch REQ_DATA[k] into the value register, src=k, pointer=(k+1) mod NREQ, go to CONV.
  - REQ_READY is 0 in every other state.
- CONV: bin2bcd8 is fed from the value register. Its HUNDREDS/TENS/ONES are registered this cycle. Next state:
  - HUN if (hundreds!=0 or SUPPRESS=0);
  - else TEN if tens!=0;
  - else ONE.
- Emit states:
  - HUN/TEN/ONE drive OUT_DATA = 8'h30 + the matching digit. SEPB drives SEP with OUT_LAST=1.
  - OUT_VALID=1 in all four. OUT_SRC = src.
  - Advance only on OUT_VALID & OUT_READY: HUN->TEN->ONE->SEPB->IDLE.
  - While OUT_READY=0, OUT_DATA, OUT_LAST and OUT_SRC must be held stable.
- Suppression keeps inner zeros: 100 emits "100", 5 emits "5", 0 emits "0". ONE is always emitted.
- Latency: accept at cycle t, CONV at t+1, first byte valid at t+2. With OUT_READY held high, bytes appear on consecutive cycles. Next accept is possible in the cycle after the SEP handshake.
- Fairness: with all requesters continuously valid, grant order is 0,1,..,NREQ-1,0,...
- A requester dropping REQ_VALID before being granted is ignored. REQ_DATA is sampled only in the accept cycle.
- Reset mid-string aborts it: no further bytes and no OUT_LAST for the aborted number. After release, start from IDLE with pointer=0.
- OUT_VALID, OUT_DATA, OUT_LAST and OUT_SRC are decoded from registered state only, with no combinational path from OUT_READY. REQ_READY is combinational from REQ_VALID and registered state only.

Decomposition:
- Shared defines file bcd_defs: state encodings, ASCII_ZERO=8'h30, default separator 8'h2C.
- Reuse the existing bin2bcd8 unchanged (one instance).
- One natural new sub-module: rr_arbiter, parameter N, inputs req/pointer, output one-hot grant.

Test Plan:
- Requester 0 only, value 8'd255, OUT_READY=1 -> bytes 0x32,0x35,0x35,0x2C on cycles t+2..t+5; OUT_LAST only on 0x2C; OUT_SRC=0.
- SUPPRESS=1: values 0, 7, 40, 100, 205 -> "0,", "7,", "40,", "100,", "205,". With SUPPRESS=0, value 7 -> "007,".
- All 4 requesters valid with values 1,2,3,4, held continuously -> grants 0,1,2,3,0; stream "1,2,3,4,1,..."; OUT_SRC matches each number.
- Backpressure: OUT_READY toggled 1,0,0,1 during value 123 -> OUT_DATA held at the stalled byte, no byte dropped or duplicated, full string "123,".
- Reset asserted after the '1' of 123 is accepted -> OUT_VALID=0 and REQ_READY=0 immediately, BUSY=0. After release, requester 2 (value 9) is granted and emits "9," with OUT_SRC=2.
- Exhaustive: values 0..255 through requester 1 -> each string matches an independent decimal formatter.

Source files
------------

// File: rtl/bcd_ascii_sched_pkg.sv
// Shared definitions for the byte-to-decimal-ASCII scheduler.
// Holds the FSM state encoding and the ASCII constants.
package bcd_ascii_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_HUN,
    ST_TEN,
    ST_ONE,
    ST_SEPB
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] DEFAULT_SEP = 8'h2C;

  function automatic logic [7:0] digit_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'd0, digit};
  endfunction

endpackage

// File: rtl/bcd_ascii_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping around; the grant is one-hot or all-zero.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  grant
);

  // Distance of a requester from the pointer in search order.
  function automatic int offset(input int idx, input logic [PW-1:0] ptr);
    return (idx + N - int'(ptr)) % N;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_grant
      logic blocked;
      always_comb begin
        blocked = 1'b0;
        for (int j = 0; j < N; j++) begin
          if (req[j] && (offset(j, pointer) < offset(gi, pointer))) blocked = 1'b1;
        end
      end
      assign grant[gi] = req[gi] & ~blocked;
    end
  endgenerate

endmodule

// File: rtl/bin2bcd8.sv
// Combinational 8-bit binary to 3-digit BCD converter (shift-and-add-3).
module bin2bcd8 (
  input  logic [7:0] BIN,
  output logic [3:0] HUNDREDS,
  output logic [3:0] TENS,
  output logic [3:0] ONES
);

  logic [19:0] shift_d;

  always_comb begin
    shift_d = {12'd0, BIN};
    for (int i = 0; i < 8; i++) begin
      if (shift_d[11:8] >= 4'd5)  shift_d[11:8]  = shift_d[11:8]  + 4'd3;
      if (shift_d[15:12] >= 4'd5) shift_d[15:12] = shift_d[15:12] + 4'd3;
      if (shift_d[19:16] >= 4'd5) shift_d[19:16] = shift_d[19:16] + 4'd3;
      shift_d = shift_d << 1;
    end
  end

  assign HUNDREDS = shift_d[19:16];
  assign TENS     = shift_d[15:12];
  assign ONES     = shift_d[11:8];

endmodule

// File: rtl/bcd_ascii_sched.sv
// Shares one bin2bcd8 among NREQ byte requesters and streams each granted
// value as decimal ASCII followed by a separator byte.
module bcd_ascii_sched
  import bcd_ascii_sched_pkg::*;
#(
  parameter int         NREQ     = 4,
  parameter logic [7:0] SEP      = DEFAULT_SEP,
  parameter bit         SUPPRESS = 1'b1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [8*NREQ-1:0] REQ_DATA,
  output logic [NREQ-1:0]   REQ_READY,
  output logic              OUT_VALID,
  output logic [7:0]        OUT_DATA,
  output logic              OUT_LAST,
  output logic [2:0]        OUT_SRC,
  input  logic              OUT_READY,
  output logic              BUSY
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [7:0]      value_q, value_d;
  logic [3:0]      hun_q, hun_d;
  logic [3:0]      ten_q, ten_d;
  logic [3:0]      one_q, one_d;
  logic [2:0]      src_q, src_d;

  logic [NREQ-1:0] grant;
  logic [3:0]      bcd_hun, bcd_ten, bcd_one;
  logic [7:0]      sel_data;
  logic [2:0]      sel_src;
  logic [PW-1:0]   sel_ptr;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req     (REQ_VALID),
    .pointer (ptr_q),
    .grant   (grant)
  );

  bin2bcd8 u_bcd (
    .BIN      (value_q),
    .HUNDREDS (bcd_hun),
    .TENS     (bcd_ten),
    .ONES     (bcd_one)
  );

  // Reset also masks the grant so nothing appears accepted while held.
  assign REQ_READY = (state_q == ST_IDLE && !RESET) ? grant : '0;

  always_comb begin
    sel_data = '0;
    sel_src  = '0;
    sel_ptr  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_data = REQ_DATA[k*8 +: 8];
        sel_src  = 3'(k);
        sel_ptr  = (k == NREQ - 1) ? '0 : PW'(k + 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    value_d = value_q;
    hun_d   = hun_q;
    ten_d   = ten_q;
    one_d   = one_q;
    src_d   = src_q;
    case (state_q)
      ST_IDLE: begin
        if (|REQ_READY) begin
          value_d = sel_data;
          src_d   = sel_src;
          ptr_d   = sel_ptr;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        hun_d = bcd_hun;
        ten_d = bcd_ten;
        one_d = bcd_one;
        // Leading zeros are skipped, but the ones digit is always emitted.
        if (bcd_hun != 4'd0 || !SUPPRESS) state_d = ST_HUN;
        else if (bcd_ten != 4'd0)         state_d = ST_TEN;
        else                              state_d = ST_ONE;
      end
      ST_HUN:  if (OUT_READY) state_d = ST_TEN;
      ST_TEN:  if (OUT_READY) state_d = ST_ONE;
      ST_ONE:  if (OUT_READY) state_d = ST_SEPB;
      ST_SEPB: if (OUT_READY) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    OUT_VALID = 1'b0;
    OUT_DATA  = 8'h00;
    OUT_LAST  = 1'b0;
    case (state_q)
      ST_HUN:  begin OUT_VALID = 1'b1; OUT_DATA = digit_ascii(hun_q); end
      ST_TEN:  begin OUT_VALID = 1'b1; OUT_DATA = digit_ascii(ten_q); end
      ST_ONE:  begin OUT_VALID = 1'b1; OUT_DATA = digit_ascii(one_q); end
      ST_SEPB: begin OUT_VALID = 1'b1; OUT_DATA = SEP; OUT_LAST = 1'b1; end
      default: ;
    endcase
  end

  assign OUT_SRC = src_q;
  assign BUSY    = (state_q != ST_IDLE);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      value_q <= '0;
      hun_q   <= '0;
      ten_q   <= '0;
      one_q   <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      value_q <= value_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      one_q   <= one_d;
      src_q   <= src_d;
    end
  end

endmodule
